// File: rtl/second_largest_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : second_largest_frame_ctrl_if
// Description : Sample-in / result-out handshake bundle for the per-frame
//               max / second-max controller. The master modport is the
//               environment (sample source plus result consumer). The slave
//               modport is the controller itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface second_largest_frame_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    // Sample stream
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;

    // Per-frame result
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_second;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

    // Environment side: drives samples, consumes results
    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_max,
        input  out_second,
        input  out_count,
        input  out_valid
    );

    // Controller side
    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_max,
        output out_second,
        output out_count,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/second_largest_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : second_largest_frame_ctrl
// Description : Groups an unsigned sample stream into frames of up to
//               FRAME_LEN beats (or fewer when closed by in_last). Tracks the
//               running largest and second-largest values, then presents
//               them with the beat count on a registered output handshake.
//               The tracker clears itself when the result is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module second_largest_frame_ctrl #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    second_largest_frame_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_frame_len = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    // ACCUM: collecting beats. HOLD: result presented, input stalled.
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State registers (_q) and their next-state values (_d)
    // ------------------------------------------------------------------
    state_t           r_state_q,      w_state_d;
    logic             r_in_ready_q,   w_in_ready_d;
    logic             r_out_valid_q,  w_out_valid_d;
    logic [WIDTH-1:0] r_max_q,        w_max_d;
    logic [WIDTH-1:0] r_second_q,     w_second_d;
    logic [CNT_W-1:0] r_count_q,      w_count_d;
    logic [WIDTH-1:0] r_out_max_q,    w_out_max_d;
    logic [WIDTH-1:0] r_out_second_q, w_out_second_d;
    logic [CNT_W-1:0] r_out_count_q,  w_out_count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_beat;        // sample accepted this cycle
    logic             w_close;       // this beat ends the frame
    logic             w_accept;      // result taken by the consumer
    logic [WIDTH-1:0] w_upd_max;     // tracker value after this beat
    logic [WIDTH-1:0] w_upd_second;
    logic [CNT_W-1:0] w_upd_count;

    // The handshake uses only the registered in_ready / out_valid, so no input
    // reaches an output without passing through a flop.
    assign w_beat   = bus.in_valid && r_in_ready_q;
    assign w_accept = r_out_valid_q && bus.out_ready;

    // Candidate tracker update. Ties push the old max down into second, so
    // repeated maxima report max == second.
    always_comb begin
        w_upd_max    = r_max_q;
        w_upd_second = r_second_q;
        if (bus.in_data >= r_max_q) begin
            w_upd_second = r_max_q;
            w_upd_max    = bus.in_data;
        end else if (bus.in_data >= r_second_q) begin
            w_upd_second = bus.in_data;
        end
        w_upd_count = r_count_q + c_one;
    end

    // A full frame and in_last on the same beat both mean one close. They
    // do not mean two.
    assign w_close = w_beat && ((w_upd_count == c_frame_len) || bus.in_last);

    // Next-state logic for the frame controller, tracker and output holding registers
    always_comb begin
        w_state_d      = r_state_q;
        w_in_ready_d   = r_in_ready_q;
        w_out_valid_d  = r_out_valid_q;
        w_max_d        = r_max_q;
        w_second_d     = r_second_q;
        w_count_d      = r_count_q;
        w_out_max_d    = r_out_max_q;
        w_out_second_d = r_out_second_q;
        w_out_count_d  = r_out_count_q;

        case (r_state_q)
            ST_ACCUM: begin
                // in_ready comes back one cycle after reset or after a result
                // is accepted, because it is registered.
                w_in_ready_d  = 1'b1;
                w_out_valid_d = 1'b0;
                if (w_beat) begin
                    w_max_d    = w_upd_max;
                    w_second_d = w_upd_second;
                    w_count_d  = w_upd_count;
                end
                if (w_close) begin
                    // The close beat is part of the frame, so publish the
                    // post-update values.
                    w_state_d      = ST_HOLD;
                    w_in_ready_d   = 1'b0;
                    w_out_valid_d  = 1'b1;
                    w_out_max_d    = w_upd_max;
                    w_out_second_d = w_upd_second;
                    w_out_count_d  = w_upd_count;
                end
            end

            ST_HOLD: begin
                // Input is ignored here. The result stays frozen until taken.
                w_in_ready_d  = 1'b0;
                w_out_valid_d = 1'b1;
                if (w_accept) begin
                    w_state_d     = ST_ACCUM;
                    w_in_ready_d  = 1'b1;
                    w_out_valid_d = 1'b0;
                    w_max_d       = '0;
                    w_second_d    = '0;
                    w_count_d     = '0;
                end
            end

            default: begin
                w_state_d     = ST_ACCUM;
                w_in_ready_d  = 1'b0;
                w_out_valid_d = 1'b0;
                w_max_d       = '0;
                w_second_d    = '0;
                w_count_d     = '0;
            end
        endcase
    end

    // State update with synchronous reset. Reset drops any partial frame or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_ACCUM;
            r_in_ready_q   <= 1'b0;
            r_out_valid_q  <= 1'b0;
            r_max_q        <= '0;
            r_second_q     <= '0;
            r_count_q      <= '0;
            r_out_max_q    <= '0;
            r_out_second_q <= '0;
            r_out_count_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_in_ready_q   <= w_in_ready_d;
            r_out_valid_q  <= w_out_valid_d;
            r_max_q        <= w_max_d;
            r_second_q     <= w_second_d;
            r_count_q      <= w_count_d;
            r_out_max_q    <= w_out_max_d;
            r_out_second_q <= w_out_second_d;
            r_out_count_q  <= w_out_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from flops
    // ------------------------------------------------------------------
    assign bus.in_ready   = r_in_ready_q;
    assign bus.out_valid  = r_out_valid_q;
    assign bus.out_max    = r_out_max_q;
    assign bus.out_second = r_out_second_q;
    assign bus.out_count  = r_out_count_q;

endmodule
`default_nettype wire
